izneuron_pool: RTL and testbench

IZNEURON_POOL -- requirements
Module: izneuron_pool

---
 rtl/izneuron_pool.sv | 240 ++++++++++++++++++++++++
 tb/tb_izneuron_pool.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/izneuron_pool.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// izneuron_pool : time-multiplexed Izhikevich neuron pool, two cycles per neuron
// Option IZN_SPIKE_HISTORY_EN: 16-sweep per-neuron spike history drives population
// Revision 1.0
// =============================================================================
module izneuron_pool #(
  parameter int NUM_NEURONS = 128,
  parameter int FRAC_BITS   = 10,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step_start,
  input  logic signed [31:0]     a_q,
  input  logic signed [31:0]     b_q,
  input  logic signed [31:0]     c_q,
  input  logic signed [31:0]     d_q,
  output logic [IDX_W-1:0]       i_idx,
  input  logic signed [31:0]     I_in,
  input  logic [IDX_W-1:0]       mon_idx,
  output logic                   busy,
  output logic                   step_done,
  output logic signed [31:0]     v_mon,
  output logic [NUM_NEURONS-1:0] population,
  output logic [IDX_W:0]         spike_count
);

  localparam logic signed [63:0] K004     = ((64'sd4 <<< FRAC_BITS) + 64'sd50) / 64'sd100;
  localparam logic signed [63:0] C140     = 64'sd140 <<< FRAC_BITS;
  localparam logic signed [63:0] V_CAP    = 64'sd100 <<< FRAC_BITS;
  localparam logic signed [31:0] V_PEAK   = 32'sd30 <<< FRAC_BITS;
  localparam logic signed [31:0] V_INIT   = -(32'sd65 <<< FRAC_BITS);
  localparam logic signed [31:0] U_INIT   = -(32'sd13 <<< FRAC_BITS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    first_q, first_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [31:0]      i_cur_q, i_cur_d;
  logic signed [31:0]      a_lat_q, a_lat_d;
  logic signed [31:0]      b_lat_q, b_lat_d;
  logic signed [31:0]      c_lat_q, c_lat_d;
  logic signed [31:0]      d_lat_q, d_lat_d;
  logic [IDX_W-1:0]        mon_lat_q, mon_lat_d;
  logic signed [31:0]      v_mon_q, v_mon_d;
  logic [NUM_NEURONS-1:0]  pop_sh_q, pop_sh_d;
  logic [IDX_W:0]          cnt_sh_q, cnt_sh_d;
  logic [NUM_NEURONS-1:0]  pop_q, pop_d;
  logic [IDX_W:0]          cnt_q, cnt_d;

  // State RAM (no reset); the first sweep substitutes the initial values instead
  logic signed [31:0]      v_mem [NUM_NEURONS];
  logic signed [31:0]      u_mem [NUM_NEURONS];
  logic signed [31:0]      v_rd_q;
  logic signed [31:0]      u_rd_q;

  logic signed [31:0]      v_cur, u_cur;
  logic signed [63:0]      v64, u64, i64, dv, v_sum, v_capped, du;
  logic signed [31:0]      v_new, u_new;
  logic                    fire;
  logic                    pop_bit;

  function automatic logic signed [63:0] qmul(input logic signed [63:0] x,
                                              input logic signed [63:0] y);
    return (x * y) >>> FRAC_BITS;
  endfunction

  always_ff @(posedge clk) begin
    if (state_q == READ) begin
      v_rd_q <= v_mem[idx_q];
      u_rd_q <= u_mem[idx_q];
    end
    if (state_q == WRITE) begin
      v_mem[idx_q] <= v_new;
      u_mem[idx_q] <= u_new;
    end
  end

  always_comb begin
    v_cur    = first_q ? V_INIT : v_rd_q;
    u_cur    = first_q ? U_INIT : u_rd_q;
    v64      = 64'(v_cur);
    u64      = 64'(u_cur);
    i64      = 64'(i_cur_q);
    dv       = qmul(qmul(K004, v64), v64) + 64'sd5 * v64 + C140 - u64 + i64;
    v_sum    = v64 + dv;
    v_capped = (v_sum > V_CAP) ? V_CAP : v_sum;
    du       = qmul(64'(a_lat_q), qmul(64'(b_lat_q), v64) - u64);
    fire     = (v_cur > V_PEAK);
    v_new    = fire ? c_lat_q : 32'(v_capped);
    u_new    = fire ? 32'(u64 + 64'(d_lat_q)) : 32'(u64 + du);
  end

`ifdef IZN_SPIKE_HISTORY_EN
  logic [15:0] hist_mem [NUM_NEURONS];
  logic [15:0] hist_rd_q;
  logic [15:0] hist_new;

  always_ff @(posedge clk) begin
    if (state_q == READ) begin
      hist_rd_q <= hist_mem[idx_q];
    end
    if (state_q == WRITE) begin
      hist_mem[idx_q] <= hist_new;
    end
  end

  // Bit 15 after the shift holds the fire from fifteen sweeps earlier
  always_comb begin
    hist_new = 16'({(first_q ? 16'd0 : hist_rd_q), fire});
    pop_bit  = hist_new[15];
  end
`else
  always_comb begin
    pop_bit = fire;
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    first_d   = first_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    i_cur_d   = i_cur_q;
    a_lat_d   = a_lat_q;
    b_lat_d   = b_lat_q;
    c_lat_d   = c_lat_q;
    d_lat_d   = d_lat_q;
    mon_lat_d = mon_lat_q;
    v_mon_d   = v_mon_q;
    pop_sh_d  = pop_sh_q;
    cnt_sh_d  = cnt_sh_q;
    pop_d     = pop_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (step_start) begin
          state_d   = READ;
          busy_d    = 1'b1;
          idx_d     = '0;
          a_lat_d   = a_q;
          b_lat_d   = b_q;
          c_lat_d   = c_q;
          d_lat_d   = d_q;
          mon_lat_d = mon_idx;
          pop_sh_d  = '0;
          cnt_sh_d  = '0;
        end
      end
      READ: begin
        i_cur_d = I_in;
        state_d = WRITE;
      end
      WRITE: begin
        pop_sh_d[idx_q] = pop_bit;
        cnt_sh_d        = cnt_sh_q + {{IDX_W{1'b0}}, fire};
        if (idx_q == mon_lat_q) begin
          v_mon_d = v_new;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        idx_d   = '0;
        first_d = 1'b0;
        pop_d   = pop_sh_q;
        cnt_d   = cnt_sh_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      first_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      i_cur_q   <= '0;
      a_lat_q   <= '0;
      b_lat_q   <= '0;
      c_lat_q   <= '0;
      d_lat_q   <= '0;
      mon_lat_q <= '0;
      v_mon_q   <= '0;
      pop_sh_q  <= '0;
      cnt_sh_q  <= '0;
      pop_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      i_cur_q   <= i_cur_d;
      a_lat_q   <= a_lat_d;
      b_lat_q   <= b_lat_d;
      c_lat_q   <= c_lat_d;
      d_lat_q   <= d_lat_d;
      mon_lat_q <= mon_lat_d;
      v_mon_q   <= v_mon_d;
      pop_sh_q  <= pop_sh_d;
      cnt_sh_q  <= cnt_sh_d;
      pop_q     <= pop_d;
      cnt_q     <= cnt_d;
    end
  end

  assign i_idx       = idx_q;
  assign busy        = busy_q;
  assign step_done   = done_q;
  assign v_mon       = v_mon_q;
  assign population  = pop_q;
  assign spike_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_izneuron_pool.sv
`timescale 1ns/1ps
`default_nettype none
// tb_izneuron_pool : directed table of sweeps plus hand-written corner sequences.
module tb_izneuron_pool;
  localparam int N         = 128;
  localparam int IW        = 7;
  localparam int SWEEP_LAT = 2 * N + 1;

  // Q10 constants: a=0.02, b=0.2, c=-65, d=8, 200.0, -100.0, -50.0, 2.0
  localparam logic signed [31:0] QA    = 32'sd20;
  localparam logic signed [31:0] QB    = 32'sd205;
  localparam logic signed [31:0] QC    = -32'sd66560;
  localparam logic signed [31:0] QD    = 32'sd8192;
  localparam logic signed [31:0] I200  = 32'sd204800;
  localparam logic signed [31:0] IM100 = -32'sd102400;
  localparam logic signed [31:0] QC50  = -32'sd51200;
  localparam logic signed [31:0] QD2   = 32'sd2048;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 step_start;
  logic signed [31:0]   a_q, b_q, c_q, d_q;
  logic [IW-1:0]        i_idx;
  logic signed [31:0]   I_in;
  logic [IW-1:0]        mon_idx;
  logic                 busy;
  logic                 step_done;
  logic signed [31:0]   v_mon;
  logic [N-1:0]         population;
  logic [IW:0]          spike_count;

  logic                 cur_all;
  logic [IW-1:0]        cur_sel;
  logic signed [31:0]   cur_val;

  int checks = 0;
  int errors = 0;

  izneuron_pool #(.NUM_NEURONS(N), .FRAC_BITS(10), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .step_start(step_start),
    .a_q(a_q), .b_q(b_q), .c_q(c_q), .d_q(d_q),
    .i_idx(i_idx), .I_in(I_in), .mon_idx(mon_idx),
    .busy(busy), .step_done(step_done), .v_mon(v_mon),
    .population(population), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  always_comb I_in = (cur_all || (i_idx == cur_sel)) ? cur_val : 32'sd0;

  typedef struct {
    string              name;
    logic signed [31:0] c;
    logic signed [31:0] d;
    logic signed [31:0] ival;
    logic               all;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      mon;
    int                 sweeps;
    logic signed [31:0] exp_v;
    logic [IW:0]        exp_cnt;
    logic [N-1:0]       exp_pop;
  } vec_t;

  vec_t vecs[6];

  task automatic chk_int(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    step_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // perturb: change mon_idx and c_q right after the sweep is accepted
  task automatic run_sweep(input bit perturb, output int lat);
    @(negedge clk) step_start = 1'b1;
    @(posedge clk);
    #1 step_start = 1'b0;
    if (perturb) begin
      mon_idx = mon_idx + IW'(1);
      c_q     = 32'sd0;
    end
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!step_done && lat < 4 * N);
  endtask

  initial begin
    int lat;
    int n_done;
    int first_at;
    logic [N-1:0] ones;
    logic [N-1:0] bit5;

    ones = '1;
    bit5 = '0;
    bit5[5] = 1'b1;

    reset = 1'b1; step_start = 1'b0;
    a_q = QA; b_q = QB; c_q = QC; d_q = QD;
    mon_idx = '0; cur_all = 1'b1; cur_sel = '0; cur_val = '0;

    // Expected v values: 0.04 is quantised to 41/1024, giving -69463 rather than -69632 after one rest sweep
    vecs[0] = '{"rest_1",      QC,   QD,  32'sd0, 1'b1, 7'd0, 7'd0,   1, -32'sd69463,  8'd0,   '0};
    vecs[1] = '{"i200_cap",    QC,   QD,  I200,   1'b1, 7'd0, 7'd3,   1,  32'sd102400, 8'd0,   '0};
    vecs[2] = '{"i200_fire",   QC,   QD,  I200,   1'b1, 7'd0, 7'd3,   2,  QC,          8'd128, ones};
    vecs[3] = '{"neg_i_last",  QC,   QD,  IM100,  1'b1, 7'd0, 7'd127, 1, -32'sd171863, 8'd0,   '0};
    vecs[4] = '{"only5_mon6",  QC,   QD,  I200,   1'b0, 7'd5, 7'd6,   2, -32'sd71389,  8'd1,   bit5};
    vecs[5] = '{"alt_cd",      QC50, QD2, I200,   1'b1, 7'd0, 7'd127, 2,  QC50,        8'd128, ones};

    do_reset();
    chk_int("rst_busy", 32'(busy), 32'sd0);
    chk_int("rst_done", 32'(step_done), 32'sd0);
    chk_int("rst_idx", 32'(i_idx), 32'sd0);
    chk_int("rst_vmon", v_mon, 32'sd0);
    chk_vec("rst_pop", population, '0);
    chk_int("rst_cnt", 32'(spike_count), 32'sd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      a_q = QA; b_q = QB; c_q = vecs[i].c; d_q = vecs[i].d;
      cur_all = vecs[i].all; cur_sel = vecs[i].sel; cur_val = vecs[i].ival;
      mon_idx = vecs[i].mon;
      for (int s = 0; s < vecs[i].sweeps; s++) begin
        run_sweep(1'b0, lat);
        chk_int({vecs[i].name, "_lat"}, lat, SWEEP_LAT);
      end
      chk_int({vecs[i].name, "_vmon"}, v_mon, vecs[i].exp_v);
      chk_int({vecs[i].name, "_cnt"}, 32'(spike_count), 32'(vecs[i].exp_cnt));
      chk_vec({vecs[i].name, "_pop"}, population, vecs[i].exp_pop);
      @(posedge clk);
      #1 chk_int({vecs[i].name, "_done_pulse"}, 32'(step_done), 32'sd0);
    end

    // step_start during a sweep (mid-sweep and in DONE) must be ignored
    do_reset();
    a_q = QA; b_q = QB; c_q = QC; d_q = QD;
    cur_all = 1'b1; cur_val = '0; mon_idx = '0;
    @(negedge clk) step_start = 1'b1;
    @(posedge clk);
    #1 step_start = 1'b0;
    chk_int("busy_after_start", 32'(busy), 32'sd1);
    n_done = 0; first_at = 0;
    for (int k = 1; k <= 2 * SWEEP_LAT + 4; k++) begin
      @(posedge clk);
      #1;
      if (step_done) begin
        n_done++;
        if (first_at == 0) first_at = k;
      end
      step_start = (k == 20 || k == 2 * N);
    end
    step_start = 1'b0;
    chk_int("ignore_ndone", n_done, 32'sd1);
    chk_int("ignore_lat", first_at, SWEEP_LAT);
    chk_int("ignore_busy_end", 32'(busy), 32'sd0);

    // Reset at index 40 after a sweep has left non-initial state in RAM
    do_reset();
    cur_all = 1'b1; cur_val = I200; mon_idx = '0;
    run_sweep(1'b0, lat);
    @(negedge clk) step_start = 1'b1;
    @(posedge clk);
    #1 step_start = 1'b0;
    lat = 0;
    while (i_idx != IW'(40) && lat < 4 * N) begin
      @(posedge clk);
      #1 lat++;
    end
    chk_int("reach_idx40", 32'(lat < 4 * N), 32'sd1);
    @(negedge clk) reset = 1'b1;
    #1;
    chk_int("abort_busy", 32'(busy), 32'sd0);
    chk_int("abort_idx", 32'(i_idx), 32'sd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < SWEEP_LAT + 4; k++) begin
      @(posedge clk);
      #1 if (step_done) n_done++;
    end
    chk_int("abort_no_done", n_done, 32'sd0);
    cur_val = '0;
    run_sweep(1'b0, lat);
    chk_int("abort_reinit_vmon", v_mon, -32'sd69463);
    chk_int("abort_reinit_cnt", 32'(spike_count), 32'sd0);

    // Parameters and monitor index are latched at step_start
    do_reset();
    a_q = QA; b_q = QB; c_q = QC; d_q = QD;
    cur_all = 1'b0; cur_sel = 7'd5; cur_val = I200; mon_idx = 7'd5;
    run_sweep(1'b1, lat);
    chk_int("latch_mon_vmon", v_mon, 32'sd102400);
    mon_idx = 7'd5; c_q = QC;
    run_sweep(1'b1, lat);
    chk_int("latch_c_vmon", v_mon, QC);
    chk_vec("latch_pop", population, bit5);

`ifdef IZN_SPIKE_HISTORY_EN
    do_reset();
    a_q = QA; b_q = QB; c_q = QC; d_q = QD;
    cur_all = 1'b1; cur_val = I200; mon_idx = '0;
    for (int s = 1; s <= 17; s++) begin
      run_sweep(1'b0, lat);
      if (s == 2) chk_int("hist_cnt_s2", 32'(spike_count), 32'sd128);
      if (s == 2) chk_vec("hist_pop_s2", population, '0);
      if (s == 16) chk_vec("hist_pop_s16", population, '0);
      if (s == 17) chk_vec("hist_pop_s17", population, ones);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
